// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Purpose  : Generic pipeline stage register with valid/ready handshake,
//            flush-to-NOP and an optional skid entry that breaks the
//            combinational ready path from downstream to upstream.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
    parameter int                WIDTH     = 16,
    parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
    parameter int                SKID      = 1,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // Main entry: always the one presented downstream.
    logic [WIDTH-1:0] r_m_data;
    logic             r_m_vld;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_accept;
    logic w_emit;

    assign w_accept  = in_valid & in_ready;
    assign w_emit    = r_m_vld & out_ready;

    assign out_valid = r_m_vld;
    assign out_data  = r_m_vld ? r_m_data : NOP_VALUE;
    assign stall_cnt = r_stall_cnt;

    generate
        if (SKID != 0) begin : g_skid
            // Skid entry absorbs the one beat that arrives after downstream
            // stalls, so in_ready can come straight from a flop.
            logic [WIDTH-1:0] r_s_data;
            logic             r_s_vld;

            assign in_ready = !r_s_vld;

            // EMPTY / FULL / SKID occupancy, encoded by the two valid flags.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_m_vld  <= 1'b0;
                    r_s_vld  <= 1'b0;
                    r_m_data <= NOP_VALUE;
                    r_s_data <= NOP_VALUE;
                end else if (flush) begin
                    r_m_vld  <= 1'b0;
                    r_s_vld  <= 1'b0;
                    r_m_data <= NOP_VALUE;
                    r_s_data <= NOP_VALUE;
                end else if (!r_m_vld) begin
                    if (w_accept) begin
                        r_m_data <= in_data;
                        r_m_vld  <= 1'b1;
                    end
                end else if (!r_s_vld) begin
                    if (w_accept && w_emit) begin
                        r_m_data <= in_data;
                    end else if (w_emit) begin
                        r_m_vld  <= 1'b0;
                    end else if (w_accept) begin
                        r_s_data <= in_data;
                        r_s_vld  <= 1'b1;
                    end
                end else begin
                    // in_ready is low here, so only an emit can move data.
                    if (w_emit) begin
                        r_m_data <= r_s_data;
                        r_s_vld  <= 1'b0;
                    end
                end
            end
        end else begin : g_no_skid
            // Single entry: can take new data when empty or draining this cycle.
            assign in_ready = !r_m_vld | out_ready;

            // EMPTY / FULL occupancy of the single main entry.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_m_vld  <= 1'b0;
                    r_m_data <= NOP_VALUE;
                end else if (flush) begin
                    r_m_vld  <= 1'b0;
                    r_m_data <= NOP_VALUE;
                end else if (w_accept) begin
                    r_m_data <= in_data;
                    r_m_vld  <= 1'b1;
                end else if (w_emit) begin
                    r_m_vld  <= 1'b0;
                end
            end
        end
    endgenerate

    // Saturating count of cycles where a live entry is held by back-pressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (r_m_vld && !out_ready && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register with a valid/ready handshake, flush-to-NOP and an optional skid entry. It replaces hand-built per-stage register banks (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic stage: each stage packs its control and data fields into one `WIDTH`-bit bus. Back-pressure from a stalled downstream stage propagates upstream through `in_ready` instead of a per-register freeze. A bubble is always presented downstream as the NOP encoding.

## Interface
- `WIDTH`, 16: payload width in bits (1..256).
- `NOP_VALUE`, {WIDTH{1'b0}}: value driven on `out_data` whenever `out_valid`=0. Also loaded by reset and flush.
- `SKID`, 1: 1 = two-entry stage with a registered `in_ready`; 0 = single entry with a combinational `in_ready`.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk` in 1: the only clock; everything samples on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `flush` in 1: discard all held entries this edge (branch mispredict / squash).
- `in_valid` in 1: upstream offers `in_data`.
- `in_ready` out 1: stage can accept this cycle.
- `in_data` in WIDTH: upstream payload.
- `out_valid` out 1: `out_data` holds a live instruction.
- `out_ready` in 1: downstream accepts this cycle (0 = stall/freeze).
- `out_data` out WIDTH: payload, or `NOP_VALUE` when not valid.
- `stall_cnt` out CNT_W: saturating count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Storage:
  - Main entry `m_data`/`m_vld` drives the outputs.
  - Skid entry `s_data`/`s_vld` exists only when `SKID`=1.
- Handshakes:
  - Accept: `in_valid & in_ready`.
  - Emit: `out_valid & out_ready`.
- States (`SKID`=1):
  - EMPTY (`m_vld`=0): accept loads main → FULL.
  - FULL (`m_vld`=1, `s_vld`=0):
    - Accept + emit: main takes the new data, stays FULL.
    - Emit only → EMPTY.
    - Accept without emit: data goes to skid → SKID.
  - SKID (both valid):
    - Emit: main ← skid, `s_vld`←0 → FULL.
    - Otherwise hold.
    - `in_ready`=0 in this state, so no accept is possible.
- `in_ready`:
  - `SKID`=1: `in_ready` = !`s_vld`, registered, with no combinational path from `out_ready`.
  - `SKID`=0: `in_ready` = !`m_vld` | `out_ready`. Same FULL/EMPTY transitions, no SKID state.
- Data order is strict FIFO; no entry is ever duplicated or dropped except by flush.
- `out_data` = `m_vld` ? `m_data` : `NOP_VALUE`.
- `flush`:
  - Next edge: `m_vld`=`s_vld`=0 and both data registers ← `NOP_VALUE`.
  - Overrides accept and emit in the same cycle. An accept coinciding with flush completes upstream but its data is discarded.
- `stall_cnt`:
  - Increments on every cycle with `out_valid` & !`out_ready`, saturating at all-ones.
  - Cleared only by reset; not cleared by flush.
- Reset (`rst`=0 at an edge) overrides flush and all handshakes:
  - `m_vld`=`s_vld`=0, data = `NOP_VALUE`, `stall_cnt`=0.
  - `in_ready`=1 from the first cycle after reset for either `SKID` value.

## Timing
- Latency: data accepted at edge N appears on `out_data` with `out_valid`=1 after edge N (one cycle) when the stage was EMPTY or emitting.
- Throughput: one transfer per cycle sustained while `out_ready`=1.
- Stall response (`SKID`=1):
  - `in_ready` falls one cycle after the skid entry fills.
  - Exactly one extra beat is absorbed after `out_ready` drops.
- Stall recovery:
  - Releasing `out_ready` from SKID emits the main entry that cycle.
  - `in_ready` returns high on the next cycle.
- Flush: `out_valid`=0 and `out_data`=`NOP_VALUE` in the cycle after the flush edge.
- During reset:
  - `out_valid`=0, `out_data`=`NOP_VALUE`, `stall_cnt`=0.
  - `in_ready`=1 after the first reset edge.
- Reset asserted mid-transfer: the transfer is lost and no partial state survives.

## Test plan
- Streaming: `WIDTH`=16, `out_ready`=1, values 0x0001..0x0010 offered back-to-back → same sequence on `out_data`, one cycle later, no gaps.
- Stall/skid: `SKID`=1, send 0xA1, 0xA2, 0xA3, drop `out_ready` while 0xA1 is at the output.
  - `in_ready`=0 after 0xA2 is absorbed; 0xA3 is held upstream.
  - Release → 0xA1, 0xA2, 0xA3 in order.
  - `stall_cnt` equals the stalled cycles.
- Flush: SKID state holding 0xB1/0xB2, `flush`=1 with `in_valid`=1 and data 0xB3 → next cycle `out_valid`=0, `out_data`=`NOP_VALUE`, `in_ready`=1, 0xB3 never appears.
- `SKID`=0 freeze: `out_ready`=0 with 0xC1 held → `in_ready`=0 in the same cycle, 0xC1 is stable, and it is emitted once on release.
- Reset: `rst`=0 for one edge during a stall with `stall_cnt`=5 → `out_valid`=0, `stall_cnt`=0, `in_ready`=1, `out_data`=`NOP_VALUE` (try `NOP_VALUE`=0xF000).
- Saturation: `CNT_W`=4 with 20 stall cycles → `stall_cnt` stops at 15.
